// File: rtl/mode_adder.sv
// mode_adder: registered WIDTH-bit adder with a per-cycle function code
// selecting unsigned, ones'-complement or two's-complement arithmetic.
// One clock of latency; result and flags (carry, overflow, zero) are registered.
// Optional feature macro: ADDER_SAT_EN -- when defined, function code 3 selects
// a saturating two's-complement add; otherwise code 3 holds all outputs.
module mode_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  input  logic [1:0]       f_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o
);

  // Function codes shared with the rest of the datapath.
  localparam logic [1:0] adder_unsigned     = 2'd0;
  localparam logic [1:0] adder_1sComplement = 2'd1;
  localparam logic [1:0] adder_2sComplement = 2'd2;
  localparam logic [1:0] adder_reserved     = 2'd3;

  localparam int MSB = WIDTH - 1;

  // Registered state and its next-state values.
  logic [WIDTH-1:0] y_reg, y_next;
  logic             c_reg, c_next;
  logic             v_reg, v_next;
  logic             z_reg, z_next;

  // Arithmetic intermediates.
  logic [WIDTH:0]   raw_sum;
  logic             carry;
  logic [WIDTH-1:0] wrap_sum;
  logic [WIDTH-1:0] ones_sum;
  logic             same_sign;
  logic             ovf_ones;
  logic             ovf_twos;

  // Saturation limits: 0111..1 and 1000..0, built bit by bit.
  logic [WIDTH-1:0] sat_max;
  logic [WIDTH-1:0] sat_min;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_sat_limits
      assign sat_max[gi] = (gi != MSB);
      assign sat_min[gi] = (gi == MSB);
    end
  endgenerate

  // Raw sum at WIDTH+1 bits, its carry, and the two candidate results.
  // The end-around-carry add cannot carry again: wrap_sum is at most
  // 2^WIDTH-2 whenever carry is set, so the extra bit is dropped.
  always_comb begin
    raw_sum   = {1'b0, a_i} + {1'b0, b_i};
    carry     = raw_sum[WIDTH];
    wrap_sum  = raw_sum[WIDTH-1:0];
    ones_sum  = wrap_sum + {{(WIDTH-1){1'b0}}, carry};
    same_sign = (a_i[MSB] == b_i[MSB]);
    ovf_ones  = same_sign && (ones_sum[MSB] != a_i[MSB]);
    ovf_twos  = same_sign && (wrap_sum[MSB] != a_i[MSB]);
  end

  // Select the result and flags for this cycle; unused codes hold state.
  always_comb begin
    y_next = y_reg;
    c_next = c_reg;
    v_next = v_reg;
    z_next = z_reg;
    unique case (f_i)
      adder_unsigned: begin
        y_next = wrap_sum;
        c_next = carry;
        v_next = 1'b0;
        z_next = (wrap_sum == '0);
      end
      adder_1sComplement: begin
        // Negative zero (all ones) is kept as-is, so z stays low for it.
        y_next = ones_sum;
        c_next = carry;
        v_next = ovf_ones;
        z_next = (ones_sum == '0);
      end
      adder_2sComplement: begin
        y_next = wrap_sum;
        c_next = carry;
        v_next = ovf_twos;
        z_next = (wrap_sum == '0);
      end
      adder_reserved: begin
`ifdef ADDER_SAT_EN
        // Clamp toward the operands' common sign when the signed add overflows.
        if (ovf_twos) begin
          y_next = a_i[MSB] ? sat_min : sat_max;
          z_next = 1'b0;
        end else begin
          y_next = wrap_sum;
          z_next = (wrap_sum == '0);
        end
        c_next = carry;
        v_next = ovf_twos;
`else
        // Reserved: every output keeps its previous value.
        y_next = y_reg;
        c_next = c_reg;
        v_next = v_reg;
        z_next = z_reg;
`endif
      end
      default: begin
        y_next = y_reg;
      end
    endcase
  end

  // Output registers; reset clears them immediately and discards any pending result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_reg <= '0;
      c_reg <= 1'b0;
      v_reg <= 1'b0;
      z_reg <= 1'b0;
    end else begin
      y_reg <= y_next;
      c_reg <= c_next;
      v_reg <= v_next;
      z_reg <= z_next;
    end
  end

  assign y_o = y_reg;
  assign c_o = c_reg;
  assign v_o = v_reg;
  assign z_o = z_reg;

endmodule

// File: tb/tb_mode_adder.sv
// Self-checking bench for mode_adder: directed steps from the test plan
// followed by random operations checked against an integer-arithmetic model.
module tb_mode_adder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst;
  logic [1:0]   f;
  logic [W-1:0] a, b;
  logic [W-1:0] y;
  logic         c, v, z;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state (expected registered outputs).
  int m_y = 0;
  int m_c = 0;
  int m_v = 0;
  int m_z = 0;

  mode_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .f_i (f),
    .a_i (a),
    .b_i (b),
    .y_o (y),
    .c_o (c),
    .v_o (v),
    .z_o (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed value of a two's-complement bit pattern.
  function automatic int twos_val(input int p);
    return (p >= M / 2) ? p - M : p;
  endfunction

  // Signed value of a ones'-complement bit pattern (all ones = negative zero).
  function automatic int ones_val(input int p);
    return (p >= M / 2) ? p - (M - 1) : p;
  endfunction

  // Compute expected outputs from the arithmetic meaning of each mode.
  task automatic model(input int fm, input int ai, input int bi);
    int sum, carry, val;
    sum   = ai + bi;
    carry = (sum >= M) ? 1 : 0;
    case (fm)
      0: begin
        m_y = sum % M; m_c = carry; m_v = 0;
      end
      1: begin
        m_y = (sum % M) + carry;
        m_c = carry;
        val = ones_val(ai) + ones_val(bi);
        m_v = (val > M / 2 - 1 || val < -(M / 2 - 1)) ? 1 : 0;
      end
      2: begin
        m_y = sum % M; m_c = carry;
        val = twos_val(ai) + twos_val(bi);
        m_v = (val > M / 2 - 1 || val < -(M / 2)) ? 1 : 0;
      end
      default: begin
`ifdef ADDER_SAT_EN
        val = twos_val(ai) + twos_val(bi);
        m_c = carry;
        if (val > M / 2 - 1) begin
          m_y = M / 2 - 1; m_v = 1;
        end else if (val < -(M / 2)) begin
          m_y = M / 2; m_v = 1;
        end else begin
          m_y = sum % M; m_v = 0;
        end
`else
        return;  // reserved: hold everything
`endif
      end
    endcase
    m_z = (m_y == 0) ? 1 : 0;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"}, int'(y), m_y);
    check({tag, ".c"}, int'(c), m_c);
    check({tag, ".v"}, int'(v), m_v);
    check({tag, ".z"}, int'(z), m_z);
    $display("[TB] %s f=%0d a=%h b=%h -> y=%h c=%0d v=%0d z=%0d", tag, f, a, b, y, c, v, z);
  endtask

  // Drive one operation between edges, clock it in, then check the outputs.
  task automatic op(input string tag, input int fm, input int ai, input int bi);
    @(negedge clk);
    f = fm[1:0]; a = ai[W-1:0]; b = bi[W-1:0];
    @(posedge clk);
    #1;
    model(fm, ai, bi);
    check_all(tag);
  endtask

  // Expected-value check against explicit plan constants.
  task automatic expect_out(input string tag, input int ey, input int ec, input int ev, input int ez);
    check({tag, ".plan_y"}, int'(y), ey);
    if (ec >= 0) check({tag, ".plan_c"}, int'(c), ec);
    if (ev >= 0) check({tag, ".plan_v"}, int'(v), ev);
    if (ez >= 0) check({tag, ".plan_z"}, int'(z), ez);
  endtask

  initial begin
    rst = 1'b0;
    f = 2'd2; a = 4'b1010; b = 4'b0111;

    // Reset held with clocks running: outputs stay clear.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    @(negedge clk);
    rst = 1'b1;

    // Unsigned wrap.
    op("uns_wrap", 0, 4'b1111, 4'b0001);
    expect_out("uns_wrap", 4'b0000, 1, 0, 1);

    // Ones'-complement end-around carry, then negative zero.
    op("ones_eac", 1, 4'b1111, 4'b0001);
    expect_out("ones_eac", 4'b0001, 1, 0, -1);
    op("ones_negz", 1, 4'b0000, 4'b1111);
    expect_out("ones_negz", 4'b1111, -1, -1, 0);

    // Two's-complement cases.
    op("twos_zero", 2, 4'b1111, 4'b0001);
    expect_out("twos_zero", 4'b0000, -1, 0, 1);
    op("twos_povf", 2, 4'b0111, 4'b0001);
    expect_out("twos_povf", 4'b1000, -1, 1, -1);
    op("twos_novf", 2, 4'b1000, 4'b1111);
    expect_out("twos_novf", 4'b0111, 1, 1, -1);

    // Latency: changing inputs between edges does not move the outputs.
    op("lat_base", 0, 4'b1111, 4'b0001);
    @(negedge clk);
    f = 2'd1;
    #2;
    check("lat_hold", int'(y), 0);
    @(posedge clk);
    #1;
    model(1, 4'b1111, 4'b0001);
    check_all("lat_next");

`ifdef ADDER_SAT_EN
    op("sat_pos", 3, 4'b0111, 4'b0001);
    expect_out("sat_pos", 4'b0111, -1, 1, -1);
    op("sat_neg", 3, 4'b1000, 4'b1111);
    expect_out("sat_neg", 4'b1000, -1, 1, -1);
    op("sat_none", 3, 4'b0010, 4'b0011);
    expect_out("sat_none", 4'b0101, -1, 0, -1);
`else
    // Reserved code holds the previous result across several edges.
    op("hold_setup", 2, 4'b0111, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      op("hold", 3, $urandom_range(0, M - 1), $urandom_range(0, M - 1));
      expect_out("hold", 4'b1000, 0, 1, 0);
    end
`endif

    // Random operations against the model.
    for (int i = 0; i < 200; i++) begin
      op("rand", $urandom_range(0, 3), $urandom_range(0, M - 1), $urandom_range(0, M - 1));
    end

    // Asynchronous reset between edges clears outputs without a clock edge.
    op("pre_rst", 0, 4'b0011, 4'b0100);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    m_y = 0; m_c = 0; m_v = 0; m_z = 0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b1;
    op("post_rst", 2, 4'b0101, 4'b0110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
